// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register index writing zero after reset or on request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_d;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_INIT, ST_CLEAR: begin
        clr_we = 1'b1;
        if (idx_q == '1) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
    // busy is registered from the next state so it always equals (state != IDLE)
    busy_d = (state_d != ST_IDLE);
  end

  assign clr_addr = idx_q;

endmodule

// File: rtl/regfile_bypass_init.sv
// Parametrised register file: synchronous write-first reads, debug tap, hardware clear.
module regfile_bypass_init
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned TAP_ADDR = 1
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic              busy
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_W;
  localparam bit                ZERO_EN = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] TAP_A   = ADDR_W'(TAP_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic [DATA_W-1:0] rd_val1, rd_val2, tap_val;

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clka    (clka),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // Writes to the hardwired zero register are dropped here, so the bypass never sees them.
  assign user_we = reg_write && !busy && !(ZERO_EN && (wr_addr == '0));

  always_ff @(posedge clka) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_val1 = (ZERO_EN && (rd_addr1 == '0))  ? '0 :
                   (user_we && (wr_addr == rd_addr1)) ? wr_data : mem[rd_addr1];
  assign rd_val2 = (ZERO_EN && (rd_addr2 == '0))  ? '0 :
                   (user_we && (wr_addr == rd_addr2)) ? wr_data : mem[rd_addr2];
  assign tap_val = (ZERO_EN && (TAP_A == '0))      ? '0 :
                   (user_we && (wr_addr == TAP_A))    ? wr_data : mem[TAP_A];

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
      tap_data <= '0;
    end else begin
      rd_valid <= rd_en && !busy;
      if (rd_en && !busy) begin
        rd_data1 <= rd_val1;
        rd_data2 <= rd_val2;
      end
      // Forced to zero on the accepting clr_req edge so the tap reads 0 for the whole busy window.
      tap_data <= (busy || clr_req) ? '0 : tap_val;
    end
  end

endmodule

// File: tb/tb_regfile_bypass_init.sv
// Directed bench for regfile_bypass_init with an array-level model, two ZERO_REG variants.
module tb_regfile_bypass_init;

  logic        clka = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic        rd_en, reg_write, clr_req;
  logic [31:0] wr_data;

  logic [31:0] z_rd1, z_rd2, z_tap, n_rd1, n_rd2, n_tap;
  logic        z_valid, z_busy, n_valid, n_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clka = ~clka;

  regfile_bypass_init #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .TAP_ADDR(1)) dut_z (
    .clka(clka), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_en(rd_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_write(reg_write), .clr_req(clr_req),
    .rd_data1(z_rd1), .rd_data2(z_rd2), .rd_valid(z_valid), .tap_data(z_tap), .busy(z_busy));

  regfile_bypass_init #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .TAP_ADDR(1)) dut_n (
    .clka(clka), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_en(rd_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_write(reg_write), .clr_req(clr_req),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .rd_valid(n_valid), .tap_data(n_tap), .busy(n_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 is the ZERO_REG=1 instance, index 1 the ZERO_REG=0 instance.
  // A clear is modelled by its net effect: the array is all zero and the file is busy 32 cycles.
  logic [31:0] mm [2][32];
  int          busy_left = 0;
  logic [31:0] e_rd1 [2], e_rd2 [2], e_tap [2];
  logic        e_valid;

  function automatic logic [31:0] peek(input int k, input logic [4:0] a);
    if (k == 0 && a == 5'd0) return 32'h0;
    if (reg_write && a == wr_addr) return wr_data;
    return mm[k][a];
  endfunction

  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = 32;
      e_valid   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_rd1[k] = 32'h0; e_rd2[k] = 32'h0; e_tap[k] = 32'h0;
        for (int a = 0; a < 32; a++) mm[k][a] = 32'h0;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      e_valid = 1'b0;
      for (int k = 0; k < 2; k++) e_tap[k] = 32'h0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en) begin
          e_rd1[k] = peek(k, rd_addr1);
          e_rd2[k] = peek(k, rd_addr2);
        end
        e_tap[k] = clr_req ? 32'h0 : peek(k, 5'd1);
      end
      e_valid = rd_en;
      for (int k = 0; k < 2; k++)
        if (reg_write && !(k == 0 && wr_addr == 5'd0)) mm[k][wr_addr] = wr_data;
      if (clr_req) begin
        busy_left = 32;
        for (int k = 0; k < 2; k++)
          for (int a = 0; a < 32; a++) mm[k][a] = 32'h0;
      end
    end
  end

  always @(negedge clka) begin
    if (chk_on) begin
      chk("z_rd_data1", z_rd1, e_rd1[0]);
      chk("z_rd_data2", z_rd2, e_rd2[0]);
      chk("z_tap_data", z_tap, e_tap[0]);
      chk("z_rd_valid", {31'b0, z_valid}, {31'b0, e_valid});
      chk("z_busy", {31'b0, z_busy}, {31'b0, busy_left > 0});
      chk("n_rd_data1", n_rd1, e_rd1[1]);
      chk("n_rd_data2", n_rd2, e_rd2[1]);
      chk("n_tap_data", n_tap, e_tap[1]);
      chk("n_rd_valid", {31'b0, n_valid}, {31'b0, e_valid});
      chk("n_busy", {31'b0, n_busy}, {31'b0, busy_left > 0});
    end
  end

  // Counts posedges until busy drops, including the edge that clears it.
  task automatic count_busy(output int cnt);
    cnt = 0;
    do begin
      @(posedge clka);
      #1;
      cnt++;
    end while (z_busy && cnt < 100);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } vec_t;

  vec_t vecs [8] = '{
    '{1'b1, 5'd2, 32'h1111_1111, 1'b0, 5'd0, 5'd0},
    '{1'b1, 5'd3, 32'h2222_2222, 1'b1, 5'd2, 5'd3},
    '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd2},
    '{1'b1, 5'd0, 32'h0BAD_F00D, 1'b1, 5'd0, 5'd1},
    '{1'b1, 5'd1, 32'h0000_0077, 1'b1, 5'd1, 5'd0},
    '{1'b0, 5'd0, 32'h0,         1'b0, 5'd5, 5'd5},
    '{1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 5'd9, 5'd5},
    '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd9}
  };

  task automatic idle_inputs();
    rd_en = 1'b0; reg_write = 1'b0; clr_req = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clka);
    chk_on = 1'b1;
    chk("reset_busy", {31'b0, z_busy}, 32'd1);
    chk("reset_valid", {31'b0, z_valid}, 32'd0);
    @(negedge clka);
    #2 rst_n = 1'b1;

    count_busy(cnt);
    chk("init_busy_cycles", cnt, 32'd32);
    @(negedge clka);

    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      @(negedge clka);
      chk("init_read_valid", {31'b0, z_valid}, 32'd1);
      chk("init_read_zero", z_rd1, 32'h0);
    end
    idle_inputs();

    reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    @(negedge clka);
    reg_write = 1'b0; rd_en = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd7;
    @(negedge clka);
    chk("r5_port1", z_rd1, 32'hDEAD_BEEF);
    chk("r7_port2", z_rd2, 32'h0);

    reg_write = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234_5678;
    rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    @(negedge clka);
    chk("bypass_port1", z_rd1, 32'h1234_5678);
    chk("bypass_port2", z_rd2, 32'h1234_5678);

    rd_en = 1'b0; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    @(negedge clka);
    reg_write = 1'b0; rd_en = 1'b1; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    @(negedge clka);
    chk("r0_zero_reg1", z_rd1, 32'h0);
    chk("r0_zero_reg0", n_rd1, 32'hFFFF_FFFF);

    rd_en = 1'b0; reg_write = 1'b1; wr_addr = 5'd1; wr_data = 32'd42;
    @(negedge clka);
    reg_write = 1'b0;
    chk("tap_after_write", z_tap, 32'd42);
    @(negedge clka);
    chk("hold_valid_low", {31'b0, z_valid}, 32'd0);

    clr_req = 1'b1;
    @(posedge clka);
    #1;
    clr_req = 1'b0;
    chk("clear_busy_rise", {31'b0, z_busy}, 32'd1);
    reg_write = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    rd_en = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd1;
    count_busy(cnt);
    reg_write = 1'b0; rd_en = 1'b0;
    chk("clear_busy_cycles", cnt, 32'd32);
    chk("tap_after_clear", z_tap, 32'h0);
    @(negedge clka);
    rd_en = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd1;
    @(negedge clka);
    chk("r3_write_dropped", z_rd1, 32'h0);
    chk("r1_cleared", z_rd2, 32'h0);

    foreach (vecs[i]) begin
      reg_write = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr1 = vecs[i].a1; rd_addr2 = vecs[i].a2;
      @(negedge clka);
    end
    idle_inputs();
    chk("vec_last_read", z_rd1, 32'hCAFE_F00D);

    clr_req = 1'b1;
    @(posedge clka);
    #1;
    clr_req = 1'b0;
    repeat (10) @(posedge clka);
    #1 rst_n = 1'b0;
    @(negedge clka);
    chk("midclr_reset_busy", {31'b0, z_busy}, 32'd1);
    chk("midclr_reset_rd1", z_rd1, 32'h0);
    chk("midclr_reset_rd2n", n_rd1, 32'h0);
    chk("midclr_reset_tap", n_tap, 32'h0);
    @(negedge clka);
    #2 rst_n = 1'b1;
    count_busy(cnt);
    chk("reinit_busy_cycles", cnt, 32'd32);
    @(negedge clka);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr1 = 5'(9 + i); rd_addr2 = 5'(2 + i);
      @(negedge clka);
    end
    idle_inputs();
    @(negedge clka);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_init.md
Name: regfile_bypass_init

Overview:
- Parametrised general-purpose register file for the single-cycle/multicycle CPU datapath; successor to the fixed 32x32 file.
- Generic width and depth; optional hardwired zero register.
- Synchronous reads with write-to-read bypass; registered debug tap of one architectural register.
- Hardware clear sequencer: zeroes every entry after reset or on request, so no X values reach the ALU.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W (derived, not overridable).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded.
- TAP_ADDR, 1, index of the register mirrored on tap_data.

Ports:
- clka  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_en  in  1  capture read addresses this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- reg_write  in  1  write enable.
- clr_req  in  1  single-cycle pulse: start clear of the whole file.
- rd_data1  out  DATA_W  registered read data, port 1.
- rd_data2  out  DATA_W  registered read data, port 2.
- rd_valid  out  1  rd_data1/2 hold data for a read accepted last cycle.
- tap_data  out  DATA_W  registered copy of register TAP_ADDR.
- busy  out  1  clear sequence in progress; writes and reads are blocked.

Behaviour:
- Reset (rst_n=0, async):
  - rd_data1, rd_data2, tap_data, rd_valid = 0; busy = 1.
  - FSM -> INIT; clear counter clr_idx = 0.
  - Array contents are not reset directly; INIT clears them.
- FSM states:
  - INIT: each cycle write 0 to entry clr_idx, then clr_idx++. After writing entry 2**ADDR_W-1 -> IDLE. Takes exactly 2**ADDR_W cycles after rst_n deasserts.
  - IDLE: normal operation, busy = 0. clr_req=1 -> CLEAR with clr_idx = 0; busy rises the next cycle.
  - CLEAR: identical to INIT; returns to IDLE.
  - clr_req while busy is ignored.
  - Reset mid-INIT or mid-CLEAR restarts INIT from index 0.
- Write, IDLE only:
  - If reg_write=1, entry wr_addr <= wr_data at posedge.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
  - While busy, reg_write is ignored (no queuing).
- Read, IDLE only:
  - If rd_en=1 at posedge N, rd_dataX show the addressed contents after posedge N and rd_valid=1 for that one cycle.
  - If rd_en=0, rd_dataX hold their previous value and rd_valid=0.
  - While busy: rd_valid=0 and rd_dataX hold.
- Bypass: if reg_write=1 and wr_addr==rd_addrX (non-zero, or ZERO_REG=0) in the same cycle, rd_dataX returns wr_data (write-first). Both ports bypass independently.
- Zero register: with ZERO_REG=1, reads of address 0 return 0 regardless of array contents.
- tap_data:
  - Updates every IDLE cycle with the contents of TAP_ADDR, write-first bypass included.
  - During INIT/CLEAR it reads 0.
  - Latency is 1 cycle after the write.
- No simulation delays and no $display in the RTL; all outputs are driven from flops.

Decomposition:
- Package regfile_pkg holds:
  - FSM state encoding (INIT, IDLE, CLEAR; 2 bits).
  - Default DATA_W/ADDR_W constants shared with the datapath top.
- Sub-module regfile_clear_seq contains the FSM and clr_idx counter. It outputs busy, clr_we, and clr_addr to the array, which muxes them over the user write port.

Test Plan:
- Reset then release: busy=1 for exactly 32 cycles, then 0; reads of addresses 0..31 all return 0 with rd_valid=1 one cycle after rd_en.
- Write 0xDEADBEEF to r5, then read r5 on port 1 and r7 on port 2 the next cycle: rd_data1=0xDEADBEEF, rd_data2=0.
- Same-cycle write 0x12345678 to r9 with rd_addr1=rd_addr2=9 and rd_en=1: both ports return 0x12345678 the next cycle.
- With ZERO_REG=1, write 0xFFFFFFFF to r0 then read r0: returns 0. With ZERO_REG=0 in the same test, it returns 0xFFFFFFFF.
- Write 42 to r1: tap_data=42 one cycle later. Pulse clr_req: busy=1 for 32 cycles, tap_data=0. A write of 7 to r3 during the clear is dropped; r3 reads 0 afterwards.
- Assert rst_n=0 at clear index 10, release: busy lasts a full 32 cycles from release, and all outputs read 0 during reset.
